crossbar_resp: RTL and testbench

//  Return-path (D-channel) router of the crossbar; counterpart of the A-channel address decoder.
//  - Records the decoded chip index of every accepted request in an in-order FIFO.
//  - Steers the matching chip's response back to the single master.
//  - Synthesizes a denied response for unmapped addresses.
//  - Strictly in-order: one master, responses returned in request order.

---
 rtl/crossbar_resp.sv | 205 ++++++++++++++++++++
 tb/tb_crossbar_resp.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_resp.sv
// Return-path (D-channel) router: tracks the chip of each accepted request in order and steers
// that chip's response to the master. Optional CROSSBAR_RESP_TIMEOUT_EN adds a denied-response timeout.
module crossbar_resp #(
  parameter int NCHIP   = 5,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_fire,
  input  logic [5:0]            chip_sel,
  input  logic                  a_unmapped,
  output logic                  a_block,
  input  logic [NCHIP-1:0]      s_d_valid,
  input  logic [64*NCHIP-1:0]   s_d_data,
  input  logic [NCHIP-1:0]      s_d_denied,
  output logic [NCHIP-1:0]      s_d_ready,
  output logic                  d_valid,
  output logic [63:0]           d_data,
  output logic                  d_denied,
  input  logic                  d_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 2) || (TIMEOUT > 65536)
      || (NCHIP < 1) || (NCHIP > 63)) begin : g_bad_params
    $error("crossbar_resp: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [6:0]       fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;

  logic [6:0]       head;
  logic             head_unmapped;
  logic [NCHIP-1:0] head_onehot;
  logic [63:0]      head_data;
  logic             head_denied;
  logic             head_valid;
  logic             head_blocked;
  logic             head_accept;
  logic             take_unmapped;
  logic             timeout_fire;
  logic [NCHIP-1:0] drop_take;
  logic             push;
  logic             pop;

  assign push = a_fire;
  assign head = fifo_mem[rd_ptr];

  // Out-of-range chip indices are routed like unmapped addresses so they can never hang the FIFO.
  assign head_unmapped = head[6] || (head[5:0] >= 6'(NCHIP));

  always_comb begin
    head_onehot = '0;
    head_data   = '0;
    head_denied = 1'b0;
    for (int i = 0; i < NCHIP; i++) begin
      if (!head_unmapped && (head[5:0] == 6'(i))) begin
        head_onehot[i] = 1'b1;
        head_data      = s_d_data[64*i +: 64];
        head_denied    = s_d_denied[i];
      end
    end
  end

  assign head_valid    = |(s_d_valid & head_onehot);
  assign head_accept   = (state == WAIT) && head_valid && !head_blocked;
  assign take_unmapped = (state == WAIT) && head_unmapped;
  assign pop           = head_accept || take_unmapped || timeout_fire;

  always_comb begin
    s_d_ready = '0;
    if (head_accept) begin
      s_d_ready = head_onehot;
    end else begin
      s_d_ready = drop_take;
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {a_unmapped, chip_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      a_block <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count   <= count_next;
      a_block <= (count_next == CW'(DEPTH));
    end
  end

  // Response capture is registered, so a new capture can only follow a completed handshake by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      d_valid  <= 1'b0;
      d_data   <= '0;
      d_denied <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count_next != '0) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (pop) begin
            d_valid  <= 1'b1;
            d_data   <= head_accept ? head_data : 64'd0;
            d_denied <= head_accept ? head_denied : 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (d_ready) begin
            d_valid <= 1'b0;
            state   <= (count_next != '0) ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CROSSBAR_RESP_TIMEOUT_EN
  logic [15:0]      tcnt;
  logic [NCHIP-1:0] drop;
  logic             drop_found;

  assign head_blocked = |(drop & head_onehot);
  assign timeout_fire = (state == WAIT) && !head_unmapped && !head_valid
                        && (tcnt == 16'(TIMEOUT - 1));

  // A late response from a timed-out chip is swallowed here; lowest index first keeps s_d_ready one-hot.
  always_comb begin
    drop_take  = '0;
    drop_found = 1'b0;
    if (!head_accept) begin
      for (int i = 0; i < NCHIP; i++) begin
        if (!drop_found && drop[i] && s_d_valid[i]) begin
          drop_take[i] = 1'b1;
          drop_found   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
      drop <= '0;
    end else begin
      if ((state == WAIT) && !pop) begin
        if (!head_valid) begin
          tcnt <= tcnt + 16'd1;
        end
      end else begin
        tcnt <= '0;
      end
      drop <= (drop & ~drop_take) | (timeout_fire ? head_onehot : '0);
    end
  end
`else
  assign head_blocked = 1'b0;
  assign timeout_fire = 1'b0;
  assign drop_take    = '0;
`endif

`ifndef SYNTHESIS
  a_push_full: assert property (@(posedge clk) disable iff (reset) a_fire |-> !a_block);
  a_sel_range: assert property (@(posedge clk) disable iff (reset)
                                (a_fire && !a_unmapped) |-> (chip_sel < 6'(NCHIP)));
  a_ready_oh:  assert property (@(posedge clk) disable iff (reset) $onehot0(s_d_ready));
`endif

endmodule

// File: tb/tb_crossbar_resp.sv
// Directed self-checking bench for crossbar_resp: ordering, full/backpressure, unmapped and reset cases.
module tb_crossbar_resp;

  localparam int NCHIP   = 5;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam logic [NCHIP-1:0] NONE = '0;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 a_fire;
  logic [5:0]           chip_sel;
  logic                 a_unmapped;
  logic                 a_block;
  logic [NCHIP-1:0]     s_d_valid;
  logic [64*NCHIP-1:0]  s_d_data;
  logic [NCHIP-1:0]     s_d_denied;
  logic [NCHIP-1:0]     s_d_ready;
  logic                 d_valid;
  logic [63:0]          d_data;
  logic                 d_denied;
  logic                 d_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crossbar_resp #(.NCHIP(NCHIP), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_fire     (a_fire),
    .chip_sel   (chip_sel),
    .a_unmapped (a_unmapped),
    .a_block    (a_block),
    .s_d_valid  (s_d_valid),
    .s_d_data   (s_d_data),
    .s_d_denied (s_d_denied),
    .s_d_ready  (s_d_ready),
    .d_valid    (d_valid),
    .d_data     (d_data),
    .d_denied   (d_denied),
    .d_ready    (d_ready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fire, input logic [5:0] sel, input logic unm,
                               input logic [NCHIP-1:0] valid, input logic rdy);
    a_fire     = fire;
    chip_sel   = sel;
    a_unmapped = unm;
    s_d_valid  = valid;
    d_ready    = rdy;
  endtask

  task automatic setResp(input int chip, input logic [63:0] data, input logic den);
    s_d_data[64*chip +: 64] = data;
    s_d_denied[chip]        = den;
  endtask

  task automatic checkResp(input string tag, input logic [63:0] data, input logic den);
    checkOutput({tag, "_valid"},  64'(d_valid),  64'd1);
    checkOutput({tag, "_data"},   d_data,        data);
    checkOutput({tag, "_denied"}, 64'(d_denied), 64'(den));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    s_d_data   = '0;
    s_d_denied = '0;
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_a_block",  64'(a_block),   64'd0);
    checkOutput("rst_s_d_ready", 64'(s_d_ready), 64'd0);
    checkOutput("rst_d_valid",  64'(d_valid),   64'd0);
    checkOutput("rst_d_data",   d_data,         64'd0);
    checkOutput("rst_d_denied", 64'(d_denied),  64'd0);

    // T1: single RAM request, response valid two cycles after a_fire
    applyStimulus(1'b1, 6'd4, 1'b0, NONE, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);
    checkOutput("t1_no_early", 64'(d_valid), 64'd0);
    step();
    setResp(4, 64'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b10000, 1'b0);
    #1;
    checkOutput("t1_sready", 64'(s_d_ready), 64'h10);
    checkOutput("t1_latency", 64'(d_valid), 64'd0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("t1", 64'hDEAD_BEEF, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);
    checkOutput("t1_dvalid_drop", 64'(d_valid), 64'd0);

    // T2: ROM then UART; UART answers first and must stall until ROM is returned
    applyStimulus(1'b1, 6'd1, 1'b0, NONE, 1'b0);
    step();
    applyStimulus(1'b1, 6'd2, 1'b0, NONE, 1'b0);
    step();
    setResp(2, 64'h2222_0002, 1'b1);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b00100, 1'b0);
    #1;
    checkOutput("t2_uart_stall", 64'(s_d_ready), 64'd0);
    step();
    checkOutput("t2_no_resp", 64'(d_valid), 64'd0);
    setResp(1, 64'h1111_0001, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b00110, 1'b0);
    #1;
    checkOutput("t2_rom_ready", 64'(s_d_ready), 64'h02);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b00100, 1'b0);
    checkResp("t2_rom", 64'h1111_0001, 1'b0);
    #1;
    checkOutput("t2_resp_ready", 64'(s_d_ready), 64'd0);
    d_ready = 1'b1;
    step();
    d_ready = 1'b0;
    checkOutput("t2_hs", 64'(d_valid), 64'd0);
    #1;
    checkOutput("t2_uart_ready", 64'(s_d_ready), 64'h04);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("t2_uart", 64'h2222_0002, 1'b1);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);

    // T4: unmapped request gets a synthesized denied response, no chip is handshaken
    applyStimulus(1'b1, 6'd0, 1'b1, NONE, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b00001, 1'b0);
    #1;
    checkOutput("t4_no_sready", 64'(s_d_ready), 64'd0);
    checkOutput("t4_not_yet", 64'(d_valid), 64'd0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("t4", 64'd0, 1'b1);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);

    // T3: fill the FIFO with four outstanding requests, then free one slot
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 6'(i), 1'b0, NONE, 1'b0);
      step();
      if (i == DEPTH - 1) checkOutput("t3_not_full", 64'(a_block), 64'd0);
    end
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);
    checkOutput("t3_full", 64'(a_block), 64'd1);
    setResp(1, 64'h33, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b00010, 1'b0);
    step();
    checkOutput("t3_unblock", 64'(a_block), 64'd0);
    checkResp("t3", 64'h33, 1'b0);

    // T5: master backpressure holds the response and stalls the next chip
    setResp(2, 64'h44, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b00100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("t5_hold_valid", 64'(d_valid), 64'd1);
      checkOutput("t5_hold_data", d_data, 64'h33);
      checkOutput("t5_stall", 64'(s_d_ready), 64'd0);
      step();
    end
    d_ready = 1'b1;
    #1;
    checkOutput("t5_no_bypass", 64'(s_d_ready), 64'd0);
    step();
    d_ready = 1'b0;
    checkOutput("t5_hs", 64'(d_valid), 64'd0);
    #1;
    checkOutput("t5_next_ready", 64'(s_d_ready), 64'h04);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("t5_uart", 64'h44, 1'b0);
    step();
    setResp(3, 64'h55, 1'b1);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b01000, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("t5_mmio", 64'h55, 1'b1);
    step();
    setResp(4, 64'h66, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b10000, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("t5_ram", 64'h66, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);
    checkOutput("t5_drained", 64'(d_valid), 64'd0);

    // Push and pop in the same cycle with one entry outstanding
    applyStimulus(1'b1, 6'd4, 1'b0, NONE, 1'b0);
    step();
    setResp(4, 64'h77, 1'b0);
    applyStimulus(1'b1, 6'd1, 1'b0, 5'b10000, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("bnd_first", 64'h77, 1'b0);
    step();
    setResp(1, 64'h88, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b00010, 1'b0);
    #1;
    checkOutput("bnd_retained", 64'(s_d_ready), 64'h02);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("bnd_second", 64'h88, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);

    // Reset while a response is held and another entry is queued
    applyStimulus(1'b1, 6'd3, 1'b0, NONE, 1'b0);
    step();
    setResp(3, 64'hAA, 1'b0);
    applyStimulus(1'b1, 6'd2, 1'b0, 5'b01000, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b00100, 1'b0);
    checkResp("mr_held", 64'hAA, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("mr_d_valid", 64'(d_valid), 64'd0);
    checkOutput("mr_d_data", d_data, 64'd0);
    checkOutput("mr_s_d_ready", 64'(s_d_ready), 64'd0);
    step();
    checkOutput("mr_idle_ready", 64'(s_d_ready), 64'd0);
    applyStimulus(1'b1, 6'd4, 1'b0, NONE, 1'b0);
    step();
    setResp(4, 64'h99, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b10100, 1'b0);
    #1;
    checkOutput("mr_fresh_head", 64'(s_d_ready), 64'h10);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("mr_new", 64'h99, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);

`ifdef CROSSBAR_RESP_TIMEOUT_EN
    // T6: MMIO never answers in time; denied response after 8 WAIT cycles, late reply absorbed
    applyStimulus(1'b1, 6'd3, 1'b0, NONE, 1'b0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);
    repeat (TIMEOUT - 1) step();
    checkOutput("t6_not_yet", 64'(d_valid), 64'd0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b1);
    checkResp("t6", 64'd0, 1'b1);
    step();
    setResp(3, 64'hBAD, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b01000, 1'b0);
    #1;
    checkOutput("t6_absorb", 64'(s_d_ready), 64'h08);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, 5'b01000, 1'b0);
    #1;
    checkOutput("t6_drop_clear", 64'(s_d_ready), 64'd0);
    checkOutput("t6_no_leak", 64'(d_valid), 64'd0);
    step();
    applyStimulus(1'b0, 6'd0, 1'b0, NONE, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
